// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//
// Receive half of the UART. Oversamples the asynchronous rx line on the
// system clock. Frames 7- or 8-bit characters with optional odd/even parity.
// Presents each received byte with a ready flag and error status.
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   rx           asynchronous serial input, idles high
//   eight        1 = 8 data bits, 0 = 7 data bits
//   pen          parity enable
//   ohel         parity sense, 1 = odd, 0 = even
//   clear_rdy    one-cycle acknowledge strobe from the processor read decode
//   rx_data      received character, right-justified, bit 7 = 0 in 7-bit mode
//   rx_rdy       byte available
//   framing_err  stop bit sampled low on the last frame
//   parity_err   parity mismatch on the last frame
//   overrun_err  a frame completed while rx_rdy was still set (sticky)

module uart_rx_engine #(
  parameter int CLK_FREQ = 100 * 10**6,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       clear_rdy,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       framing_err,
  output logic       parity_err,
  output logic       overrun_err
);

  localparam int          BIT_TIME  = CLK_FREQ / BAUD;
  localparam int          HALF      = BIT_TIME / 2;
  localparam logic [19:0] BIT_TERM  = 20'(BIT_TIME - 1);
  localparam logic [19:0] HALF_TERM = 20'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        rx_meta;
  logic        rx_s;
  logic        rx_s_d;
  logic [19:0] count;
  logic        tick;
  logic [3:0]  bit_cnt;
  logic [8:0]  shreg;
  logic        eight_f;
  logic        pen_f;
  logic        ohel_f;
  logic [3:0]  n_bits;
  logic        start_edge;
  logic        frame_done;
  logic [8:0]  aligned;
  logic [7:0]  data_bits;
  logic        parity_bit;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  // Resetting to 1 makes the line look idle, so a low line after reset does
  // not count as a start edge until rx_s has actually been high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign start_edge = rx_s_d & ~rx_s;

  // Number of line samples taken in DATA: data bits plus the parity bit.
  assign n_bits = 4'd7 + {3'b000, eight_f} + {3'b000, pen_f};

  // The START state waits half a bit to land in the middle of the start bit;
  // every later sample is a full bit time after the previous one.
  assign tick = (state == START) ? (count == HALF_TERM) : (count == BIT_TERM);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. frame_done marks the stop-bit sample, which is also
  // the cycle in which all frame results are registered.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          // A high line at the start-bit centre was a glitch.
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && (bit_cnt == n_bits - 4'd1)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit timer: restarts on every state change and after every tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 20'd0;
    end else if ((state == IDLE) || tick || (state_next != state)) begin
      count <= 20'd0;
    end else begin
      count <= count + 20'd1;
    end
  end

  // Frame format is captured at the start edge so mode changes mid-frame
  // cannot corrupt the character being received.
  always_ff @(posedge clock) begin
    if (reset) begin
      eight_f <= 1'b0;
      pen_f   <= 1'b0;
      ohel_f  <= 1'b0;
    end else if ((state == IDLE) && start_edge) begin
      eight_f <= eight;
      pen_f   <= pen;
      ohel_f  <= ohel;
    end
  end

  // Bit counter and shift register. Bits enter at the MSB so that after
  // N samples the first (LSB) bit sits at position 9-N.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= 4'd0;
      shreg   <= 9'd0;
    end else if (state == START) begin
      bit_cnt <= 4'd0;
    end else if ((state == DATA) && tick) begin
      bit_cnt <= bit_cnt + 4'd1;
      shreg   <= {rx_s, shreg[8:1]};
    end
  end

  assign aligned    = shreg >> (4'd9 - n_bits);
  assign data_bits  = eight_f ? aligned[7:0] : {1'b0, aligned[6:0]};
  assign parity_bit = pen_f & (eight_f ? aligned[8] : aligned[7]);

  // Output registers. On the stop-bit sample the set of rx_rdy wins over a
  // coincident clear_rdy, but that clear still suppresses the overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data     <= 8'h00;
      rx_rdy      <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (frame_done) begin
      rx_data     <= data_bits;
      rx_rdy      <= 1'b1;
      framing_err <= ~rx_s;
      parity_err  <= pen_f & ((^data_bits ^ parity_bit) != ohel_f);
      overrun_err <= ~clear_rdy & (overrun_err | rx_rdy);
    end else if (clear_rdy) begin
      rx_rdy      <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine
//
// Directed bench for uart_rx_engine. One instance runs at a 16-cycle bit
// time for the functional cases; a second instance at default parameters
// receives one full-rate frame. Inputs change and outputs are sampled on
// the falling clock edge.

module tb_uart_rx_engine;

  localparam int BT_SM  = 16;
  localparam int HF_SM  = 8;
  localparam int BT_DEF = 868;
  localparam int HF_DEF = 434;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_sm;
  logic       rx_def;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       clear_rdy;
  logic [7:0] data_sm;
  logic       rdy_sm;
  logic       fe_sm;
  logic       pe_sm;
  logic       oe_sm;
  logic [7:0] data_def;
  logic       rdy_def;
  logic       fe_def;
  logic       pe_def;
  logic       oe_def;

  int n_compared = 0;
  int n_mismatch = 0;
  int rdy_at;

  always #5 clock = ~clock;

  uart_rx_engine #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx_sm),
    .eight       (eight),
    .pen         (pen),
    .ohel        (ohel),
    .clear_rdy   (clear_rdy),
    .rx_data     (data_sm),
    .rx_rdy      (rdy_sm),
    .framing_err (fe_sm),
    .parity_err  (pe_sm),
    .overrun_err (oe_sm)
  );

  uart_rx_engine dut_def (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx_def),
    .eight       (eight),
    .pen         (pen),
    .ohel        (ohel),
    .clear_rdy   (clear_rdy),
    .rx_data     (data_def),
    .rx_rdy      (rdy_def),
    .framing_err (fe_def),
    .parity_err  (pe_def),
    .overrun_err (oe_def)
  );

  // One comparison: counts it, and on a difference reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatch++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one frame: start bit, nbits payload bits LSB first, then the stop
  // bit. Returns the first cycle index (counted from the start-bit edge) at
  // which rx_rdy reads 1. clr_at >= 0 pulses clear_rdy for one cycle there.
  task automatic applyStimulus(input bit use_def, input int bt,
                               input logic [8:0] payload, input int nbits,
                               input logic stop_val, input int clr_at,
                               output int first_rdy);
    int   total;
    int   idx;
    logic lv;
    first_rdy = -1;
    total = (nbits + 2) * bt;
    if (use_def) rx_def = 1'b0; else rx_sm = 1'b0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clock);
      if (((use_def ? rdy_def : rdy_sm) == 1'b1) && (first_rdy < 0)) first_rdy = c;
      if (c == clr_at) clear_rdy = 1'b1;
      if (c == clr_at + 1) clear_rdy = 1'b0;
      if (((c % bt) == 0) && (c < total)) begin
        idx = c / bt;
        lv = (idx <= nbits) ? payload[idx - 1] : stop_val;
        if (use_def) rx_def = lv; else rx_sm = lv;
      end
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulseClear();
    @(negedge clock);
    clear_rdy = 1'b1;
    @(negedge clock);
    clear_rdy = 1'b0;
  endtask

  function automatic logic [31:0] status_sm();
    return {28'd0, rdy_sm, fe_sm, pe_sm, oe_sm};
  endfunction

  initial begin
    reset     = 1'b1;
    rx_sm     = 1'b1;
    rx_def    = 1'b1;
    eight     = 1'b1;
    pen       = 1'b0;
    ohel      = 1'b0;
    clear_rdy = 1'b0;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);

    // Reset state (status packed as rdy,fe,pe,oe).
    checkOutput("reset_data", {24'd0, data_sm}, 32'h00);
    checkOutput("reset_status", status_sm(), 32'b0000);
    checkOutput("reset_def_status", {28'd0, rdy_def, fe_def, pe_def, oe_def}, 32'b0000);

    // 8N1 0xA5, with rx_rdy latency from the start edge.
    $display("[TB] 8N1 0xA5");
    applyStimulus(1'b0, BT_SM, 9'h0A5, 8, 1'b1, -1, rdy_at);
    checkOutput("a5_rdy_cycle", rdy_at, 2 + HF_SM + 9 * BT_SM + 1);
    checkOutput("a5_data", {24'd0, data_sm}, 32'hA5);
    checkOutput("a5_status", status_sm(), 32'b1000);
    pulseClear();
    checkOutput("a5_cleared", status_sm(), 32'b0000);

    // 7E1 0x41: correct parity, then wrong parity bit.
    $display("[TB] 7E1 0x41");
    eight = 1'b0;
    pen   = 1'b1;
    ohel  = 1'b0;
    waitCycles(4);
    applyStimulus(1'b0, BT_SM, 9'h041, 8, 1'b1, -1, rdy_at);
    checkOutput("e41_data", {24'd0, data_sm}, 32'h41);
    checkOutput("e41_status", status_sm(), 32'b1000);
    pulseClear();
    applyStimulus(1'b0, BT_SM, 9'h0C1, 8, 1'b1, -1, rdy_at);
    checkOutput("e41_bad_data", {24'd0, data_sm}, 32'h41);
    checkOutput("e41_bad_status", status_sm(), 32'b1010);
    pulseClear();

    // 8N1 0x3C with low stop bit, then line held low, then 0x00.
    $display("[TB] framing error");
    eight = 1'b1;
    pen   = 1'b0;
    waitCycles(4);
    applyStimulus(1'b0, BT_SM, 9'h03C, 8, 1'b0, -1, rdy_at);
    checkOutput("fe_data", {24'd0, data_sm}, 32'h3C);
    checkOutput("fe_status", status_sm(), 32'b1100);
    pulseClear();
    waitCycles(5 * BT_SM);
    checkOutput("low_line_no_frame", status_sm(), 32'b0100);
    rx_sm = 1'b1;
    waitCycles(BT_SM);
    applyStimulus(1'b0, BT_SM, 9'h000, 8, 1'b1, -1, rdy_at);
    checkOutput("zero_data", {24'd0, data_sm}, 32'h00);
    checkOutput("zero_status", status_sm(), 32'b1000);
    pulseClear();

    // Overrun: two back-to-back frames with no acknowledge.
    $display("[TB] overrun");
    applyStimulus(1'b0, BT_SM, 9'h011, 8, 1'b1, -1, rdy_at);
    applyStimulus(1'b0, BT_SM, 9'h022, 8, 1'b1, -1, rdy_at);
    checkOutput("ovr_data", {24'd0, data_sm}, 32'h22);
    checkOutput("ovr_status", status_sm(), 32'b1001);
    pulseClear();
    checkOutput("ovr_cleared", status_sm(), 32'b0000);

    // Same again, clear_rdy lands on the stop-bit sample edge.
    applyStimulus(1'b0, BT_SM, 9'h011, 8, 1'b1, -1, rdy_at);
    applyStimulus(1'b0, BT_SM, 9'h022, 8, 1'b1, 2 + HF_SM + 9 * BT_SM, rdy_at);
    checkOutput("clr_on_stop_data", {24'd0, data_sm}, 32'h22);
    checkOutput("clr_on_stop_status", status_sm(), 32'b1000);

    // Short low glitch must be rejected by START.
    $display("[TB] glitch and reset");
    waitCycles(4);
    rx_sm = 1'b0;
    waitCycles(4);
    rx_sm = 1'b1;
    waitCycles(3 * BT_SM);
    checkOutput("glitch_data", {24'd0, data_sm}, 32'h22);
    checkOutput("glitch_status", status_sm(), 32'b1000);

    // Reset during the data bits of a 0xFF frame.
    rx_sm = 1'b0;
    waitCycles(BT_SM);
    rx_sm = 1'b1;
    waitCycles(3 * BT_SM);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("midreset_data", {24'd0, data_sm}, 32'h00);
    checkOutput("midreset_status", status_sm(), 32'b0000);
    waitCycles(8 * BT_SM);
    checkOutput("midreset_no_frame", status_sm(), 32'b0000);
    applyStimulus(1'b0, BT_SM, 9'h05A, 8, 1'b1, -1, rdy_at);
    checkOutput("after_reset_data", {24'd0, data_sm}, 32'h5A);
    checkOutput("after_reset_status", status_sm(), 32'b1000);

    // Full-rate 8O1 0x80, parity bit 0 gives odd overall parity.
    $display("[TB] default rate 8O1 0x80");
    eight = 1'b1;
    pen   = 1'b1;
    ohel  = 1'b1;
    waitCycles(4);
    applyStimulus(1'b1, BT_DEF, 9'h080, 9, 1'b1, -1, rdy_at);
    checkOutput("def_rdy_cycle", rdy_at, 2 + HF_DEF + 10 * BT_DEF + 1);
    checkOutput("def_data", {24'd0, data_def}, 32'h80);
    checkOutput("def_status", {28'd0, rdy_def, fe_def, pe_def, oe_def}, 32'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Receive half of the UART: oversamples the asynchronous serial line on the 100 MHz system clock, frames 7- or 8-bit characters with optional parity, and presents each received byte with a ready flag and error status. It sits between the board RX pin and the TramelBlaze read port. The processor consumes bytes from it, and the LED output stage displays the received data and status.

## Interface
- CLK_FREQ, 100 * 10**6, system clock frequency in Hz.
- BAUD, 115200, line rate. BIT_TIME = CLK_FREQ/BAUD (integer divide; 868 at defaults). HALF = BIT_TIME/2 (434).
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  parity enable.
- ohel  in  1  parity sense: 1 = odd, 0 = even.
- clear_rdy  in  1  one-cycle strobe from the processor read decode that acknowledges the current byte.
- rx_data  out  8  received character, LSB-first on the line, right-justified. Bit 7 is 0 in 7-bit mode.
- rx_rdy  out  1  byte available.
- framing_err  out  1  stop bit sampled low on the last frame.
- parity_err  out  1  parity mismatch on the last frame. Always 0 when pen was 0.
- overrun_err  out  1  a frame completed while rx_rdy was still set; sticky.

## Operation
- Input synchronizer: two flops (reset value 1) produce rx_s. A third flop holds rx_s_d, which is used for falling-edge detect.
- eight, pen and ohel are latched on the start-edge detection cycle and held for the whole frame. N = 7 + eight + pen (7..9).
- Bit timer: a 20-bit up-counter. It clears on every state entry and on every tick. A tick fires when count == TERM-1; TERM = HALF in START and BIT_TIME otherwise.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_s_d=1 and rx_s=0, go to START. A line held low never retriggers.
  - START: on tick, sample rx_s. If 0, go to DATA with bit count 0. If 1 (glitch), go to IDLE with no flag change.
  - DATA: on each tick, shift rx_s into the MSB of a 9-bit shift register and increment the bit count. After N samples, go to STOP.
  - STOP: on tick, sample the stop bit and go to IDLE. In the same cycle, register all frame results:
    - rx_data: data bits right-justified. The parity bit is excluded; bit 7 is forced to 0 when eight=0.
    - framing_err = ~rx_s.
    - parity_err = pen & ((XOR of data bits ^ parity bit) != ohel).
    - rx_rdy is set.
    - overrun_err is set if rx_rdy was already 1 and clear_rdy is not asserted this cycle. The old rx_data is overwritten.
- clear_rdy clears rx_rdy and overrun_err. framing_err and parity_err hold until the next frame completes.
- If clear_rdy coincides with the STOP tick, set wins: rx_rdy=1 and overrun_err=0.
- A frame with a framing error still delivers its data and sets rx_rdy.

## Timing
- Reset values: rx_data=0x00, rx_rdy=0, framing_err=0, parity_err=0, overrun_err=0, FSM=IDLE, timer=0, shift register=0, synchronizer=1.
- Reset mid-frame aborts the frame with no flags; the next start requires a fresh falling edge.
- The start edge is detected 2 cycles after the rx pin falls (synchronizer). START samples HALF cycles after entry. Each later sample is BIT_TIME cycles after the previous one.
- rx_rdy and the data/error outputs become visible the cycle after the STOP tick. Latency from the detect cycle is HALF + (N+1)*BIT_TIME + 1 cycles.
- clear_rdy takes effect on the next edge. rx_rdy is low the cycle after the strobe.
- Back-to-back frames: the STOP→IDLE transition takes 1 cycle. A start bit beginning ≥HALF after the stop-bit centre is accepted.

## Test plan
- Sim params CLK_FREQ=16, BAUD=1 (BIT_TIME=16, HALF=8). Send 0xA5 at 8N1 -> rx_data=0xA5, rx_rdy=1, all errors 0. rx_rdy rises 8+9*16+1=153 cycles after the detect cycle.
- 7 data bits, even parity (eight=0, pen=1, ohel=0): send 0x41 with parity bit 0 -> rx_data=0x41, parity_err=0. Resend with parity bit 1 -> parity_err=1, rx_rdy=1.
- 8N1, stop bit driven low, data 0x3C -> rx_data=0x3C, framing_err=1. Hold rx low 5 bit times -> no new frame. Release, then send 0x00 -> framing_err=0.
- Two frames 0x11 then 0x22 without clear_rdy -> rx_data=0x22, overrun_err=1. Pulse clear_rdy -> rx_rdy=0, overrun_err=0. Repeat with clear_rdy on the exact STOP-tick cycle -> rx_rdy=1, overrun_err=0.
- Low glitch of 4 cycles on idle line -> START rejects and returns to IDLE, outputs unchanged. Assert reset during DATA of a 0xFF frame -> all outputs 0. A following 0x5A frame is received correctly.
- Default params: 8O1 frame 0x80 with parity bit 0 at BIT_TIME=868 -> rx_data=0x80, parity_err=0.
